// File: rtl/mono_data_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : mono_data_rx_if
//  Description : Word stream between the mono_data_rx receiver and a FIFO.
//                A word moves when fifo_valid and fifo_ready are both high.
//                  fifo_data  [31:0] : decoded frame word (source -> sink)
//                  fifo_valid        : word valid        (source -> sink)
//                  fifo_ready        : sink accepts word (sink -> source)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mono_data_rx_if;
  logic [31:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_ready;

  modport master (output fifo_data, output fifo_valid, input fifo_ready);
  modport slave  (input fifo_data, input fifo_valid, output fifo_ready);
endinterface
`default_nettype wire

// File: rtl/mono_data_rx.sv
`default_nettype none
// ============================================================================
//  Module      : mono_data_rx
//  Description : Readout controller for a monolithic pixel chip. When the chip
//                raises TOKEN the block freezes the chip, pulses READ, shifts in
//                one serial frame {col[5:0], row[7:0], LE[5:0], TE[5:0]} (MSB
//                first) and hands it to a FIFO. It loops while TOKEN stays
//                high, then unfreezes.
//                clk_i also drives the chip Clk_Out; DATA is sampled on its
//                rising edge.
//  Ports       : clk_i, rst_i          clock, synchronous active-high reset
//                enable_i              arm the readout loop (sampled in IDLE)
//                freeze_dly_i[3:0]     FREEZE rise to first READ (0 -> 1)
//                read_len_i[3:0]       READ pulse width (0 -> 1)
//                read_gap_i[3:0]       READ fall to first DATA sample
//                token_i, data_i       chip token and serial data
//                freeze_o, read_o      chip control strobes (registered)
//                fifo_m                word output (mono_data_rx_if.master)
//                word_cnt_o            frames pushed, saturating
//                stall_cnt_o           PUSH cycles with ready low, saturating
//                busy_o                high whenever the FSM is not IDLE
//  Options     : MONO_RX_GRAY_DECODE_EN - when defined, LE and TE are converted
//                from Gray to binary while loading the output word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mono_data_rx #(
  parameter int FRAME_BITS = 26,
  parameter int CNT_W      = 16
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic             enable_i,
  input  wire logic [3:0]       freeze_dly_i,
  input  wire logic [3:0]       read_len_i,
  input  wire logic [3:0]       read_gap_i,
  input  wire logic             token_i,
  input  wire logic             data_i,
  output logic                  freeze_o,
  output logic                  read_o,
  mono_data_rx_if.master        fifo_m,
  output logic [CNT_W-1:0]      word_cnt_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic                  busy_o
);

  localparam int                BIT_W      = $clog2(FRAME_BITS);
  localparam int                PAD_W      = 32 - FRAME_BITS;
  localparam logic [BIT_W-1:0]  C_LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0]  C_BIT_ONE  = BIT_W'(1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FRZ   = 3'd1,
    S_RD    = 3'd2,
    S_GAP   = 3'd3,
    S_SHIFT = 3'd4,
    S_PUSH  = 3'd5,
    S_UNFRZ = 3'd6
  } state_t;

  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic [BIT_W-1:0]       bit_q;
  logic [FRAME_BITS-2:0]  shift_q;      // bits received so far; the last bit comes straight from data_i
  logic [1:0]             tok_sync_q;
  logic                   freeze_q;
  logic                   read_q;
  logic                   fifo_valid_q;
  logic [31:0]            fifo_data_q;
  logic [CNT_W-1:0]       word_cnt_q;
  logic [CNT_W-1:0]       stall_cnt_q;

  logic [FRAME_BITS-1:0]  shift_d;
  logic [FRAME_BITS-1:0]  push_frame_d;
  logic [3:0]             dly_m1_d;
  logic [3:0]             len_m1_d;
  logic                   token_go_d;

  // Counters count down to zero, so load "length minus one"; 0 behaves as 1.
  assign dly_m1_d   = (freeze_dly_i == 4'd0) ? 4'd0 : freeze_dly_i - 4'd1;
  assign len_m1_d   = (read_len_i   == 4'd0) ? 4'd0 : read_len_i   - 4'd1;
  // A dropped ENABLE masks the token so the running loop ends after this word.
  assign token_go_d = tok_sync_q[1] & enable_i;
  assign shift_d    = {shift_q, data_i};

`ifdef MONO_RX_GRAY_DECODE_EN
  function automatic logic [5:0] gray2bin(input logic [5:0] g);
    logic [5:0] b;
    b[5] = g[5];
    for (int i = 4; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign push_frame_d = {shift_d[FRAME_BITS-1:12], gray2bin(shift_d[11:6]), gray2bin(shift_d[5:0])};
`else
  assign push_frame_d = shift_d;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      bit_q        <= '0;
      shift_q      <= '0;
      tok_sync_q   <= 2'b00;
      freeze_q     <= 1'b0;
      read_q       <= 1'b0;
      fifo_valid_q <= 1'b0;
      fifo_data_q  <= 32'd0;
      word_cnt_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      tok_sync_q <= {tok_sync_q[0], token_i};
      case (state_q)
        S_IDLE: begin
          if (enable_i && tok_sync_q[1]) begin
            state_q  <= S_FRZ;
            freeze_q <= 1'b1;
            cnt_q    <= dly_m1_d;
          end
        end
        S_FRZ: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RD;
            read_q  <= 1'b1;
            cnt_q   <= len_m1_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RD: begin
          if (cnt_q == 4'd0) begin
            read_q <= 1'b0;
            bit_q  <= C_LAST_BIT;
            if (read_gap_i == 4'd0) begin
              state_q <= S_SHIFT;
            end else begin
              state_q <= S_GAP;
              cnt_q   <= read_gap_i - 4'd1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_SHIFT;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_SHIFT: begin
          shift_q <= shift_d[FRAME_BITS-2:0];
          if (bit_q == '0) begin
            // The final bit is taken from data_i directly so the word is
            // ready on the same edge as the last sample.
            state_q      <= S_PUSH;
            fifo_valid_q <= 1'b1;
            fifo_data_q  <= {{PAD_W{1'b0}}, push_frame_d};
          end else begin
            bit_q <= bit_q - C_BIT_ONE;
          end
        end
        S_PUSH: begin
          if (fifo_m.fifo_ready) begin
            fifo_valid_q <= 1'b0;
            if (word_cnt_q != C_CNT_MAX) begin
              word_cnt_q <= word_cnt_q + C_CNT_ONE;
            end
            if (token_go_d) begin
              state_q <= S_RD;
              read_q  <= 1'b1;
              cnt_q   <= len_m1_d;
            end else begin
              state_q  <= S_UNFRZ;
              freeze_q <= 1'b0;
              cnt_q    <= 4'd1;
            end
          end else if (stall_cnt_q != C_CNT_MAX) begin
            stall_cnt_q <= stall_cnt_q + C_CNT_ONE;
          end
        end
        S_UNFRZ: begin
          // Two cycles for the chip token to settle after unfreezing.
          if (cnt_q == 4'd0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          freeze_q     <= 1'b0;
          read_q       <= 1'b0;
          fifo_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign freeze_o          = freeze_q;
  assign read_o            = read_q;
  assign fifo_m.fifo_data  = fifo_data_q;
  assign fifo_m.fifo_valid = fifo_valid_q;
  assign word_cnt_o        = word_cnt_q;
  assign stall_cnt_o       = stall_cnt_q;
  assign busy_o            = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mono_data_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mono_data_rx
//  Description : Self-checking bench for mono_data_rx. Stimulus serialises
//                frames and queues the expected words; a monitor acting as the
//                FIFO drives ready, pops and compares words, and a timing
//                monitor checks FREEZE/READ pulse placement.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mono_data_rx;

  logic        clk = 1'b0;
  logic        rst, enable, token, data;
  logic [3:0]  dly, len, gap;
  logic        freeze, read, busy;
  logic [15:0] wcnt, scnt;

  always #5 clk = ~clk;

  mono_data_rx_if u_if ();

  mono_data_rx #(.FRAME_BITS(26), .CNT_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .freeze_dly_i (dly),
    .read_len_i   (len),
    .read_gap_i   (gap),
    .token_i      (token),
    .data_i       (data),
    .freeze_o     (freeze),
    .read_o       (read),
    .fifo_m       (u_if),
    .word_cnt_o   (wcnt),
    .stall_cnt_o  (scnt),
    .busy_o       (busy)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          exp_words = 0;
  int          exp_stall = 0;
  int          force_stall = -1;

  // Expected word: six zero bits then the frame; LE/TE Gray-decoded when the
  // option is built in (binary bit i is the XOR of Gray bits i and above).
  function automatic logic [31:0] model_word(input logic [25:0] f);
    logic [25:0] r;
    r = f;
`ifdef MONO_RX_GRAY_DECODE_EN
    for (int i = 0; i < 6; i++) begin
      r[6+i] = ^(f[11:6] >> i);
      r[i]   = ^(f[5:0] >> i);
    end
`endif
    return {6'd0, r};
  endfunction

  function automatic int at_least_one(input logic [3:0] v);
    return (v == 4'd0) ? 1 : int'(v);
  endfunction

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // sel: 0 = read, 1 = fifo_valid, other = busy. Checks before waiting.
  task automatic wait_until(input int sel, input logic val, input string name);
    for (int i = 0; i < 400; i++) begin
      logic s;
      case (sel)
        0:       s = read;
        1:       s = u_if.fifo_valid;
        default: s = busy;
      endcase
      if (s == val) return;
      @(negedge clk);
    end
    n_cmp++;
    n_err++;
    $display("FAIL timeout %s: signal never reached %0b within 400 cycles", name, val);
    finish_run();
  endtask

  // FIFO side: choose a stall length per word, drive ready, score words.
  initial begin : monitor
    int          stall_left;
    logic        hold_valid;
    logic [31:0] hold_data;
    stall_left = -1;
    hold_valid = 1'b0;
    hold_data  = 32'd0;
    u_if.fifo_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (u_if.fifo_valid) begin
        if (hold_valid) check("fifo_data_stable", u_if.fifo_data, hold_data);
        if (stall_left < 0) begin
          stall_left = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
          exp_stall += stall_left;
        end
        if (stall_left > 0) begin
          u_if.fifo_ready = 1'b0;
          stall_left--;
          hold_valid = 1'b1;
          hold_data  = u_if.fifo_data;
        end else begin
          u_if.fifo_ready = 1'b1;
          hold_valid = 1'b0;
          stall_left = -1;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_word: got 0x%08h expected no word", u_if.fifo_data);
          end else begin
            check("fifo_word", u_if.fifo_data, exp_q.pop_front());
          end
        end
      end else begin
        u_if.fifo_ready = 1'b0;
        hold_valid = 1'b0;
        stall_left = -1;
      end
    end
  end

  // FREEZE-to-READ delay and READ width measured at negedges.
  initial begin : timing_mon
    logic pf, pr, frz_pending;
    int   frz_cyc, rd_cyc;
    pf = 1'b0; pr = 1'b0; frz_pending = 1'b0; frz_cyc = 0; rd_cyc = 0;
    forever begin
      @(negedge clk);
      if (freeze && !pf) begin
        frz_pending = 1'b1;
        frz_cyc     = 0;
      end
      if (!freeze) frz_pending = 1'b0;
      if (frz_pending && freeze && !read) frz_cyc++;
      if (read && !pr) begin
        check("read_inside_freeze", 32'(freeze), 32'd1);
        if (frz_pending) check("freeze_to_read", frz_cyc, at_least_one(dly));
        frz_pending = 1'b0;
        rd_cyc      = 0;
      end
      if (read) rd_cyc++;
      if (!read && pr) check("read_width", rd_cyc, at_least_one(len));
      pf = freeze;
      pr = read;
    end
  end

  task automatic run_burst(input int n, input logic [3:0] d, input logic [3:0] l,
                           input logic [3:0] g, input bit drop_en, input bit directed,
                           input logic [25:0] dframe);
    logic [25:0] f;
    dly = d; len = l; gap = g;
    token = 1'b1; enable = 1'b1;
    for (int k = 0; k < n; k++) begin
      f = directed ? dframe : 26'($urandom);
      wait_until(0, 1'b1, "read_rise");
      wait_until(0, 1'b0, "read_fall");
      repeat (g) @(negedge clk);
      exp_q.push_back(model_word(f));
      exp_words++;
      if (k == n - 1) begin
        if (drop_en) enable = 1'b0;
        else         token  = 1'b0;
      end
      for (int b = 25; b >= 0; b--) begin
        data = f[b];
        @(negedge clk);
      end
      data = 1'($urandom);
      wait_until(1, 1'b1, "valid_rise");
      wait_until(1, 1'b0, "handshake");
      check("freeze_after_push", 32'(freeze), (k == n - 1) ? 32'd0 : 32'd1);
    end
    wait_until(2, 1'b0, "idle_return");
    check("word_cnt", 32'(wcnt), exp_words);
    check("stall_cnt", 32'(scnt), exp_stall);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  initial begin : stimulus
    logic [15:0] s0;
    logic [25:0] f;
    rst = 1'b1; enable = 1'b0; token = 1'b0; data = 1'b0;
    dly = 4'd0; len = 4'd0; gap = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_freeze", 32'(freeze), 32'd0);
    check("rst_read", 32'(read), 32'd0);
    check("rst_valid", 32'(u_if.fifo_valid), 32'd0);
    check("rst_data", u_if.fifo_data, 32'd0);
    check("rst_counts", {wcnt, scnt}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Token pending but not armed: must stay idle.
    token = 1'b1;
    repeat (10) @(negedge clk);
    check("disabled_busy", 32'(busy), 32'd0);
    check("disabled_freeze", 32'(freeze), 32'd0);
    token = 1'b0;
    repeat (3) @(negedge clk);

    // Directed single frame.
    force_stall = 0;
    run_burst(1, 4'd2, 4'd1, 4'd1, 1'b0, 1'b1, 26'h2A55A5A);
    check("first_word_cnt", 32'(wcnt), 32'd1);

    // LE field Gray 100000 (binary 111111 when decoded).
    run_burst(1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, {6'h15, 8'hC3, 6'b100000, 6'b000111});

    // Three back-to-back frames under one freeze.
    force_stall = -1;
    run_burst(3, 4'd1, 4'd3, 4'd2, 1'b0, 1'b0, 26'd0);

    // Five stalled cycles on one word.
    force_stall = 5;
    s0 = scnt;
    run_burst(1, 4'd3, 4'd2, 4'd0, 1'b0, 1'b0, 26'd0);
    check("stall_five", 32'(scnt - s0), 32'd5);
    force_stall = -1;

    // ENABLE dropped mid-frame ends the loop after the current word.
    run_burst(2, 4'd3, 4'd2, 4'd0, 1'b1, 1'b0, 26'd0);
    token = 1'b0;
    repeat (5) @(negedge clk);
    check("enable_drop_idle", 32'(busy), 32'd0);

    // Reset after ten bits of a frame: partial frame discarded.
    dly = 4'd1; len = 4'd2; gap = 4'd0;
    token = 1'b1; enable = 1'b1;
    f = 26'($urandom);
    wait_until(0, 1'b1, "rst_read_rise");
    wait_until(0, 1'b0, "rst_read_fall");
    for (int b = 25; b >= 16; b--) begin
      data = f[b];
      @(negedge clk);
    end
    rst = 1'b1; token = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_words = 0;
    exp_stall = 0;
    check("midrst_freeze_read", {30'd0, freeze, read}, 32'd0);
    check("midrst_valid_busy", {30'd0, u_if.fifo_valid, busy}, 32'd0);
    check("midrst_data", u_if.fifo_data, 32'd0);
    check("midrst_counts", {wcnt, scnt}, 32'd0);
    repeat (40) @(negedge clk);
    check("midrst_no_word", 32'(wcnt), 32'd0);

    // Randomised bursts.
    for (int t = 0; t < 6; t++) begin
      run_burst(int'($urandom_range(1, 3)), 4'($urandom), 4'($urandom), 4'($urandom),
                1'b0, 1'b0, 26'd0);
    end

    repeat (5) @(negedge clk);
    finish_run();
  end

endmodule
`default_nettype wire
